button_debounce_edge: RTL
=========================

BUTTON_DEBOUNCE_EDGE -- requirements
Module: button_debounce_edge

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 120000, the number of consecutive stable synchronized samples required to accept a level change (10 ms at 12 MHz).
REQ-002 The block SHALL expose parameter LONG_CYCLES, default 12000000, the number of debounced-pressed cycles before a long-press pulse (1 s at 12 MHz).
REQ-003 The block SHALL expose parameter CNT_W, default 24, the shared counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 btn_n  input  1  raw asynchronous push-button, active-low (0 = pressed).
REQ-007 switch_out  output  1  debounced level, active-low, registered.
REQ-008 press_pulse  output  1  one-cycle strobe on each accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-010 long_pulse  output  1  one-cycle strobe once per press held LONG_CYCLES.

Function
REQ-011 btn_n SHALL pass through a two-flop synchronizer; its second-stage output is btn_s, and no other logic SHALL sample btn_n.
REQ-012 Control SHALL be a four-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED: btn_s=0 -> PRESS_WAIT with counter cleared to 0; otherwise hold.
REQ-014 PRESS_WAIT: btn_s=0 increments counter; btn_s=1 -> RELEASED with counter cleared, no output change (glitch rejected).
REQ-015 PRESS_WAIT: the cycle btn_s=0 with counter = DEBOUNCE_CYCLES-1 -> PRESSED, switch_out<=0, press_pulse<=1, counter cleared.
REQ-016 PRESSED: btn_s=1 -> RELEASE_WAIT with counter cleared; otherwise counter increments, saturating at LONG_CYCLES.
REQ-017 PRESSED: long_pulse SHALL assert for exactly one cycle when counter reaches LONG_CYCLES, and never again until the next accepted press.
REQ-018 RELEASE_WAIT: btn_s=1 increments counter; btn_s=0 -> PRESSED with counter cleared and long-press re-armed only if it had not yet fired.
REQ-019 RELEASE_WAIT: the cycle btn_s=1 with counter = DEBOUNCE_CYCLES-1 -> RELEASED, switch_out<=1, release_pulse<=1, counter cleared.
REQ-020 Latency: a clean raw edge on btn_n SHALL appear on switch_out exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-021 press_pulse and switch_out falling SHALL occur in the same cycle; release_pulse and switch_out rising SHALL occur in the same cycle.
REQ-022 At most one of press_pulse, release_pulse, long_pulse SHALL be high in any cycle.
REQ-023 Bounce shorter than DEBOUNCE_CYCLES SHALL produce no change on any output.
REQ-024 The counter SHALL never wrap; LONG_CYCLES < 2^CNT_W and 2 <= DEBOUNCE_CYCLES <= LONG_CYCLES are legal-parameter constraints, and other values are unsupported.
REQ-025 All outputs SHALL be driven directly from flops (no combinational paths from btn_n).

Reset
REQ-026 rst_n=0 SHALL immediately force: synchronizer flops=1, FSM=RELEASED, counter=0, switch_out=1, press_pulse=0, release_pulse=0, long_pulse=0.
REQ-027 Reset asserted mid-debounce or mid-press SHALL discard progress; after deassertion, a held button SHALL require a full DEBOUNCE_CYCLES+2 before press_pulse.
REQ-028 Reset deassertion SHALL be treated as synchronous to clk by the integrator; the block adds no reset synchronizer.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 Clean press: btn_n 1->0 held 30 cycles -> switch_out=0 and press_pulse=1 on edge 6 after the first sampling edge; long_pulse=1 exactly once, 20 cycles later.
REQ-030 Bounce: btn_n toggles 0/1 with 3-cycle low runs for 20 cycles -> switch_out stays 1, all pulses stay 0.
REQ-031 Release: from PRESSED, btn_n 0->1 held -> switch_out=1 and release_pulse=1 six edges later; no long_pulse if the hold was under 20 cycles.
REQ-032 Release bounce: in PRESSED, a 2-cycle high glitch -> no release_pulse; continued hold -> no second press_pulse or long_pulse.
REQ-033 Reset mid-press: assert rst_n=0 at PRESS_WAIT count 2 with btn_n held 0 -> all outputs at reset values; after release, press_pulse appears six edges later.
REQ-034 Pulse exclusivity and single-cycle width SHALL be checked by assertion across all scenarios.

Source files
------------

// File: rtl/button_debounce_edge_if.sv
// Push-button bundle: raw active-low button in, debounced level and event strobes out.
interface button_debounce_edge_if;
  logic btn_n;
  logic switch_out;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  // Driver of the raw button and consumer of the debounced results.
  modport master (
    output btn_n,
    input  switch_out,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  // The debouncer itself.
  modport slave (
    input  btn_n,
    output switch_out,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_debounce_edge.sv
// Push-button debouncer with press/release/long-press strobes.
// The raw button is synchronized, then a four-state FSM requires DEBOUNCE_CYCLES stable samples
// before accepting a level change. One counter is shared between debounce timing and the
// long-press timer; every output comes straight from a flop.
module button_debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned CNT_W           = 24
) (
  input logic                   clk,
  input logic                   rst_n,
  button_debounce_edge_if.slave bus
);

  // Legal-parameter guards, evaluated at elaboration.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > LONG_CYCLES) begin : g_bad_debounce
    $error("button_debounce_edge: need 2 <= DEBOUNCE_CYCLES <= LONG_CYCLES");
  end
  if (CNT_W < 32 && 64'(LONG_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_width
    $error("button_debounce_edge: LONG_CYCLES does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LongPrev = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LongMax  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  logic             sync1_q;
  logic             btn_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             switch_q, switch_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  // Long-press already reported for the current accepted press.
  logic             fired_q, fired_d;

  // Two-flop synchronizer; the only logic that ever looks at the raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      btn_s   <= 1'b1;
    end else begin
      sync1_q <= bus.btn_n;
      btn_s   <= sync1_q;
    end
  end

  // FSM, shared counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReleased;
      cnt_q     <= '0;
      switch_q  <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      fired_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      switch_q  <= switch_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      fired_q   <= fired_d;
    end
  end

  // Next-state, counter and strobe decode; strobes default low so each lasts one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    switch_d  = switch_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    fired_d   = fired_q;

    unique case (state_q)
      StReleased: begin
        if (!btn_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end

      StPressWait: begin
        if (btn_s) begin
          // Glitch: drop back without touching any output.
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d  = StPressed;
          cnt_d    = '0;
          switch_d = 1'b0;
          press_d  = 1'b1;
          fired_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StPressed: begin
        if (btn_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (cnt_q != LongMax) begin
          // Saturate at LongMax so the timer can never wrap and re-fire.
          cnt_d = cnt_q + CntOne;
          if (cnt_q == LongPrev) begin
            long_d  = !fired_q;
            fired_d = 1'b1;
          end
        end
      end

      StReleaseWait: begin
        if (!btn_s) begin
          // Release glitch: resume the hold; fired_q keeps a spent long-press disarmed.
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StReleased;
          cnt_d     = '0;
          switch_d  = 1'b1;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.switch_out    = switch_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;

endmodule
